csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
Initiator side of the core's CSR bus. It executes one Zicsr instruction (CSRRW/RS/RC and their immediate forms) as a short sequence on the bus: read phase, optional write phase, then completion. The CSR responders (timer, status and similar registers) sit on the other side of the bus. The unit sits between the core's execute stage and those responders, and returns the old CSR value destined for rd.

Parameters:
- CHECK_READ_ONLY, 1: when 1, any write to an address with address[11:10]==2'b11 raises error.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request strobe; accepted only in IDLE
- op  input  3  funct3 encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; 000 and 100 are illegal
- address  input  12  CSR address
- sourceData  input  32  rs1 value
- sourceIndex  input  5  rs1 index; for the I-forms, the zimm value
- busy  output  1  high from the cycle after an accepted start until the cycle done or error is asserted, inclusive
- done  output  1  one-cycle pulse on successful completion
- error  output  1  one-cycle pulse on an illegal access
- resultData  output  32  old CSR value; valid from done, held until the next accepted start
- csrReadEnable  output  1  read strobe
- csrReadAddress  output  12  read address
- csrReadData  input  32  wired-OR read data from responders (combinational)
- csrRequestOutput  input  1  OR of the responder claim signals (combinational)
- csrWriteEnable  output  1  write strobe
- csrWriteAddress  output  12  write address
- csrWriteData  output  32  write data

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, error, csrReadEnable and csrWriteEnable all 0; resultData, csrReadAddress, csrWriteAddress and csrWriteData all 0.
- States: IDLE, READ, WRITE, DONE, ERROR.
- Capture on start in IDLE: op, address and source are registered.
  - Register/imm forms: source = sourceData for op[2]=0; source = {27'b0, sourceIndex} for op[2]=1.
  - writeNeeded = 1 for RW/RWI; otherwise writeNeeded = (sourceIndex != 0).
- IDLE transitions:
  - start with an illegal op -> ERROR.
  - start with a legal op -> READ.
- READ (one cycle):
  - csrReadEnable=1, csrReadAddress=captured address.
  - csrReadData and csrRequestOutput are sampled at the end of the cycle.
  - csrRequestOutput=0 -> ERROR (unimplemented CSR).
  - Write needed and read-only violation with CHECK_READ_ONLY=1 -> ERROR.
  - Otherwise the old value is latched into resultData, then: WRITE if writeNeeded, else DONE.
- WRITE (one cycle):
  - csrWriteEnable=1, csrWriteAddress=captured address.
  - csrWriteData: RW = source; RS = old | source; RC = old & ~source.
  - Next state DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERROR: error=1 for one cycle; resultData is not updated -> IDLE.
- Latency, with start accepted in cycle T:
  - READ at T+1.
  - WRITE at T+2, then done at T+3.
  - With no write: done at T+2.
  - Illegal op: error at T+1.
  - Unclaimed address: error at T+2.
- Strobe rules:
  - csrReadEnable and csrWriteEnable are never high in the same cycle.
  - Each is high for exactly one cycle per operation.
  - When the enables are low, the address/data outputs hold their last values.
- start is ignored in every state other than IDLE. A start in the same cycle as the done/error pulse is also ignored; the next start is accepted from the following cycle.
- Reset mid-operation: immediate return to IDLE. Any pending write is abandoned with no strobe, and no done or error is issued.
- Arithmetic: 32-bit bitwise only; zimm is zero-extended.

Test Plan:
- CSRRS, address 0xC00, responder claims with value 0x0000_1234, sourceIndex=0 -> read strobe at T+1, no write strobe, done at T+2, resultData=0x0000_1234.
- CSRRW, address 0x340, old value 0xAAAA_5555, sourceData 0x1234_5678 -> write strobe at T+2 with data 0x1234_5678 to 0x340; done at T+3; resultData=0xAAAA_5555.
- CSRRCI, zimm=0x0F, old value 0xFFFF_FFFF -> write data 0xFFFF_FFF0; CSRRSI with zimm=0x03 on old value 0x0 -> write data 0x0000_0003.
- Unclaimed address 0x7FF (csrRequestOutput=0) -> error at T+2, no write strobe, resultData unchanged.
- CSRRW to 0xC01 with CHECK_READ_ONLY=1 -> error at T+2, no write. op=100 -> error at T+1 with no read strobe.
- rst asserted during WRITE -> csrWriteEnable drops asynchronously, no done; a start issued afterwards completes normally. Starts issued while busy are ignored.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// Request and CSR-bus signal bundle for csr_access_unit.
// The master side is the access unit; the slave side is the core plus the CSR responders.
interface csr_access_unit_if;
    logic        start;
    logic [2:0]  op;
    logic [11:0] address;
    logic [31:0] sourceData;
    logic [4:0]  sourceIndex;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] resultData;
    logic        csrReadEnable;
    logic [11:0] csrReadAddress;
    logic [31:0] csrReadData;
    logic        csrRequestOutput;
    logic        csrWriteEnable;
    logic [11:0] csrWriteAddress;
    logic [31:0] csrWriteData;

    // start is a one-cycle strobe, taken only while busy is low.
    // The read and write enables are one-cycle strobes and need no acknowledge.
    // The responders answer the read in the same cycle: claim via csrRequestOutput, data via csrReadData.
    modport master (
        input  start, op, address, sourceData, sourceIndex, csrReadData, csrRequestOutput,
        output busy, done, error, resultData,
        output csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
    );

    modport slave (
        output start, op, address, sourceData, sourceIndex, csrReadData, csrRequestOutput,
        input  busy, done, error, resultData,
        input  csrReadEnable, csrReadAddress, csrWriteEnable, csrWriteAddress, csrWriteData
    );
endinterface

// File: rtl/csr_access_unit.sv
// Zicsr initiator: runs one CSRRW/RS/RC(I) as a read phase, an optional write phase,
// and a done or error pulse. It returns the old CSR value for rd.
module csr_access_unit #(
    parameter bit CHECK_READ_ONLY = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    csr_access_unit_if.master     bus,
    output logic [2:0]            state_dbg_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] src_q, src_d;
    logic        wneed_q, wneed_d;
    logic [11:0] rd_addr_q, rd_addr_d;
    logic [11:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] result_q, result_d;

    logic        op_legal;
    logic        ro_violation;
    logic [31:0] merged;

    // funct3 values x00 are not Zicsr operations
    assign op_legal     = (bus.op[1:0] != 2'b00);
    assign ro_violation = CHECK_READ_ONLY && wneed_q && (rd_addr_q[11:10] == 2'b11);

    always_comb begin
        merged = src_q;
        case (op_q[1:0])
            2'b01:   merged = src_q;
            2'b10:   merged = bus.csrReadData | src_q;
            2'b11:   merged = bus.csrReadData & ~src_q;
            default: merged = src_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        wneed_d   = wneed_q;
        rd_addr_d = rd_addr_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (op_legal) begin
                        op_d      = bus.op;
                        src_d     = bus.op[2] ? {27'b0, bus.sourceIndex} : bus.sourceData;
                        wneed_d   = (bus.op[1:0] == 2'b01) || (bus.sourceIndex != 5'd0);
                        rd_addr_d = bus.address;
                        state_d   = S_READ;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end
            S_READ: begin
                if (!bus.csrRequestOutput || ro_violation) begin
                    state_d = S_ERROR;
                end else begin
                    result_d = bus.csrReadData;
                    if (wneed_q) begin
                        wr_addr_d = rd_addr_q;
                        wr_data_d = merged;
                        state_d   = S_WRITE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 3'd0;
            src_q     <= 32'd0;
            wneed_q   <= 1'b0;
            rd_addr_q <= 12'd0;
            wr_addr_q <= 12'd0;
            wr_data_q <= 32'd0;
            result_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            wneed_q   <= wneed_d;
            rd_addr_q <= rd_addr_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            result_q  <= result_d;
        end
    end

    // Enables decode straight from state, so an async reset drops them at once
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.error           = (state_q == S_ERROR);
    assign bus.resultData      = result_q;
    assign bus.csrReadEnable   = (state_q == S_READ);
    assign bus.csrReadAddress  = rd_addr_q;
    assign bus.csrWriteEnable  = (state_q == S_WRITE);
    assign bus.csrWriteAddress = wr_addr_q;
    assign bus.csrWriteData    = wr_data_q;
    assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: the driver queues the expected strobes and completions,
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_csr_access_unit;

  logic clk;
  logic rst;
  logic [2:0] state_dbg;
  logic [15:0] cyc;

  csr_access_unit_if bus ();

  csr_access_unit #(.CHECK_READ_ONLY(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .state_dbg_o(state_dbg)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 16'd0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // Responder model: it claims one address with a fixed value.
  logic        rsp_claim;
  logic [11:0] rsp_addr;
  logic [31:0] rsp_value;
  assign bus.csrRequestOutput = rsp_claim && bus.csrReadEnable && (bus.csrReadAddress == rsp_addr);
  assign bus.csrReadData      = bus.csrRequestOutput ? rsp_value : 32'd0;

  // Scoreboard queues.
  logic [27:0] rd_exp_q[$];   // {addr, cycle}
  logic [59:0] wr_exp_q[$];   // {addr, data, cycle}
  logic [49:0] exp_q[$];      // {done, error, resultData, cycle}
  logic [31:0] exp_result;

  int checks;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: it pops an expectation each time the DUT shows a strobe or a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.csrReadEnable && bus.csrWriteEnable)
        check("strobe_overlap", 64'd1, 64'd0);
      if (bus.csrReadEnable) begin
        if (rd_exp_q.size() == 0) check("unexpected_read", {52'd0, bus.csrReadAddress}, 64'd0);
        else check("read_strobe", {36'd0, bus.csrReadAddress, cyc}, {36'd0, rd_exp_q.pop_front()});
      end
      if (bus.csrWriteEnable) begin
        if (wr_exp_q.size() == 0) check("unexpected_write", {20'd0, bus.csrWriteAddress, bus.csrWriteData}, 64'd0);
        else check("write_strobe", {4'd0, bus.csrWriteAddress, bus.csrWriteData, cyc}, {4'd0, wr_exp_q.pop_front()});
      end
      if (bus.done || bus.error) begin
        if (exp_q.size() == 0) check("unexpected_resp", {62'd0, bus.done, bus.error}, 64'd0);
        else check("response", {14'd0, bus.done, bus.error, bus.resultData, cyc}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  // Driver: it issues one instruction, holds start for hold cycles, and waits for idle.
  task automatic do_op(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] sdata,
                       input logic [4:0] sidx, input logic claim, input logic [31:0] old,
                       input logic [31:0] exp_wdata, input int hold);
    logic [15:0] t0;
    logic wn;
    int n;
    @(negedge clk);
    rsp_claim = claim;
    rsp_addr  = addr;
    rsp_value = old;
    t0 = cyc;
    check("busy_idle", {63'd0, bus.busy}, 64'd0);
    bus.start = 1'b1;
    bus.op = op;
    bus.address = addr;
    bus.sourceData = sdata;
    bus.sourceIndex = sidx;
    if (op[1:0] == 2'b00) begin
      exp_q.push_back({1'b0, 1'b1, exp_result, t0 + 16'd1});
    end else begin
      rd_exp_q.push_back({addr, t0 + 16'd1});
      wn = (op[1:0] == 2'b01) || (sidx != 5'd0);
      if (!claim || (wn && addr[11:10] == 2'b11)) begin
        exp_q.push_back({1'b0, 1'b1, exp_result, t0 + 16'd2});
      end else begin
        exp_result = old;
        if (wn) begin
          wr_exp_q.push_back({addr, exp_wdata, t0 + 16'd2});
          exp_q.push_back({1'b1, 1'b0, old, t0 + 16'd3});
        end else begin
          exp_q.push_back({1'b1, 1'b0, old, t0 + 16'd2});
        end
      end
    end
    @(negedge clk);
    check("busy_t1", {63'd0, bus.busy}, 64'd1);
    repeat (hold - 1) @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [15:0] t0;
    checks = 0;
    errors = 0;
    exp_result = 32'd0;
    rsp_claim = 1'b0;
    rsp_addr = 12'd0;
    rsp_value = 32'd0;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.address = 12'd0;
    bus.sourceData = 32'd0;
    bus.sourceIndex = 5'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", {58'd0, bus.busy, bus.done, bus.error, bus.csrReadEnable, bus.csrWriteEnable, 1'b0}, 64'd0);
    check("reset_result", {32'd0, bus.resultData}, 64'd0);
    check("reset_bus", {8'd0, bus.csrReadAddress, bus.csrWriteAddress, bus.csrWriteData}, 64'd0);
    check("reset_state", {61'd0, state_dbg}, 64'd0);
    rst = 1'b0;

    // op, addr, sourceData, sourceIndex, claim, old value, expected write data, start hold
    do_op(3'b010, 12'hC00, 32'h0000_DEAD, 5'd0,  1'b1, 32'h0000_1234, 32'h0,          1); // RS, no write
    do_op(3'b001, 12'h340, 32'h1234_5678, 5'd5,  1'b1, 32'hAAAA_5555, 32'h1234_5678,  1); // RW
    do_op(3'b111, 12'h300, 32'hFFFF_FFFF, 5'h0F, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0,  1); // RCI
    do_op(3'b110, 12'h305, 32'hFFFF_FFFF, 5'h03, 1'b1, 32'h0000_0000, 32'h0000_0003,  1); // RSI
    do_op(3'b011, 12'h341, 32'h0000_FF00, 5'd7,  1'b1, 32'h1234_5678, 32'h1234_0078,  1); // RC
    do_op(3'b001, 12'h7FF, 32'h0000_0001, 5'd1,  1'b0, 32'h0000_0000, 32'h0,          1); // unclaimed
    do_op(3'b001, 12'hC01, 32'h0000_0001, 5'd1,  1'b1, 32'h0000_0055, 32'h0,          1); // read-only write
    do_op(3'b100, 12'h340, 32'h0000_0001, 5'd1,  1'b1, 32'h0000_0011, 32'h0,          1); // illegal op
    do_op(3'b000, 12'h340, 32'h0000_0001, 5'd1,  1'b1, 32'h0000_0011, 32'h0,          1); // illegal op
    do_op(3'b110, 12'hC02, 32'h0000_0000, 5'd0,  1'b1, 32'h0000_0099, 32'h0,          1); // RSI zimm 0 on RO
    do_op(3'b001, 12'h342, 32'h0000_0002, 5'd2,  1'b1, 32'h0000_0001, 32'h0000_0002,  4); // start held while busy

    // Reset during the write phase.
    @(negedge clk);
    rsp_claim = 1'b1;
    rsp_addr  = 12'h343;
    rsp_value = 32'h0000_0F0F;
    t0 = cyc;
    bus.start = 1'b1;
    bus.op = 3'b001;
    bus.address = 12'h343;
    bus.sourceData = 32'h0000_F0F0;
    bus.sourceIndex = 5'd1;
    rd_exp_q.push_back({12'h343, t0 + 16'd1});
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    check("write_before_rst", {63'd0, bus.csrWriteEnable}, 64'd1);
    rst = 1'b1;
    #1;
    check("write_after_rst", {61'd0, bus.csrWriteEnable, bus.busy, bus.done}, 64'd0);
    check("result_after_rst", {32'd0, bus.resultData}, 64'd0);
    exp_result = 32'd0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    do_op(3'b010, 12'h344, 32'h0000_0000, 5'd0,  1'b1, 32'h0000_CAFE, 32'h0,          1); // after reset

    repeat (4) @(negedge clk);
    check("rd_q_empty", {32'd0, rd_exp_q.size()}, 64'd0);
    check("wr_q_empty", {32'd0, wr_exp_q.size()}, 64'd0);
    check("resp_q_empty", {32'd0, exp_q.size()}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
